// File: rtl/mem_pkg.sv
// Shared request/response layout for caches, memory model and arbiter.
// Request:  {data, type, valid, addr[31:0]}
// Response: {data, ready}
package mem_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned ADDR_LSB       = 0;
  localparam int unsigned VALID_BIT      = 32;
  localparam int unsigned TYPE_BIT       = 33;
  localparam int unsigned DATA_LSB       = 34;
  localparam int unsigned REQ_CTRL_W     = 34;

  localparam int unsigned RESP_READY_BIT = 0;
  localparam int unsigned RESP_DATA_LSB  = 1;

  localparam logic REQUEST_READ  = 1'b0;
  localparam logic REQUEST_WRITE = 1'b1;

  // Full request width for a given cache block size.
  function automatic int unsigned req_width(input int unsigned block_bits);
    return REQ_CTRL_W + block_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin decision: on contention, grant the port not granted last.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Single requester wins outright; contention alternates against last grant.
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_idx   = 1'b0;
    if (valid0 && valid1) begin
      grant_idx = ~last_grant;
    end else if (valid1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-cache (port 0) and data-cache (port 1) requests onto one
// memory port. One transaction in flight; responses return as one-cycle ready pulses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [REQ_CTRL_W+BLOCK_BITS-1:0] Req0,
  input  logic [REQ_CTRL_W+BLOCK_BITS-1:0] Req1,
  output logic [BLOCK_BITS:0]              Resp0,
  output logic [BLOCK_BITS:0]              Resp1,
  output logic [REQ_CTRL_W+BLOCK_BITS-1:0] MemReq,
  input  logic [BLOCK_BITS:0]              MemResp,
  output logic                             ErrTimeout
);

  localparam int unsigned ReqW    = REQ_CTRL_W + BLOCK_BITS;
  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StHold} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  port_q;
  logic                  last_q;

  logic                  grant_valid;
  logic                  grant_idx;
  logic [ReqW-1:0]       grant_req;
  logic                  granted_valid;
  logic [BLOCK_BITS-1:0] mem_data;

  rr_arbiter2 u_rr (
    .valid0      (Req0[VALID_BIT]),
    .valid1      (Req1[VALID_BIT]),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_req     = grant_idx ? Req1 : Req0;
  assign granted_valid = port_q ? Req1[VALID_BIT] : Req0[VALID_BIT];
  assign mem_data      = MemResp[BLOCK_BITS:RESP_DATA_LSB];

  // Transaction FSM; all outputs registered so MemReq ignores Req changes after grant.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      port_q     <= 1'b0;
      last_q     <= 1'b0;
      MemReq     <= '0;
      Resp0      <= '0;
      Resp1      <= '0;
      ErrTimeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            MemReq  <= grant_req;
            port_q  <= grant_idx;
            last_q  <= grant_idx;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (MemResp[RESP_READY_BIT]) begin
            MemReq[VALID_BIT] <= 1'b0;
            if (port_q) Resp1 <= {mem_data, 1'b1};
            else        Resp0 <= {mem_data, 1'b1};
            state_q <= StResp;
          end else if (cnt_q == CntLast) begin
            // Abort: answer the requester with zero data and flag it permanently.
            MemReq[VALID_BIT] <= 1'b0;
            ErrTimeout        <= 1'b1;
            if (port_q) Resp1 <= {{BLOCK_BITS{1'b0}}, 1'b1};
            else        Resp0 <= {{BLOCK_BITS{1'b0}}, 1'b1};
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          Resp0[RESP_READY_BIT] <= 1'b0;
          Resp1[RESP_READY_BIT] <= 1'b0;
          state_q               <= StHold;
        end
        StHold: begin
          // Wait for the served requester to retire its request before re-arbitrating.
          if (!granted_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple latency memory model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned BB   = 128;
  localparam int unsigned RW   = REQ_CTRL_W + BB;

  logic          CLK = 1'b0;
  logic          RST;
  logic [RW-1:0] Req0, Req1, MemReq;
  logic [BB:0]   Resp0, Resp1, MemResp;
  logic          ErrTimeout;

  int            n_chk = 0;
  int            n_fail = 0;

  // Memory model control
  int            mem_lat = 0;
  logic [BB-1:0] mem_data = '0;
  int            mcnt = 0;

  // Monitor counters
  int            r0_cnt = 0, r1_cnt = 0, mreq_cnt = 0;
  logic          prev_v = 1'b0;

  mem_arbiter #(.BLOCK_BITS(BB), .TIMEOUT(64)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Req0       (Req0),
    .Req1       (Req1),
    .Resp0      (Resp0),
    .Resp1      (Resp1),
    .MemReq     (MemReq),
    .MemResp    (MemResp),
    .ErrTimeout (ErrTimeout)
  );

  always #5 CLK = ~CLK;

  // Memory: ready pulse of one cycle after mem_lat cycles of valid; mem_lat 0 = never.
  initial begin
    MemResp = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (MemResp[0]) begin
        MemResp = '0;
        mcnt    = 0;
      end else if (MemReq[VALID_BIT] && mem_lat != 0) begin
        mcnt++;
        if (mcnt >= mem_lat) MemResp = {mem_data, 1'b1};
      end else begin
        mcnt = 0;
      end
    end
  end

  // Count ready-high cycles and MemReq valid rising edges.
  initial begin
    forever begin
      @(posedge CLK);
      #4;
      if (Resp0[0] === 1'b1) r0_cnt++;
      if (Resp1[0] === 1'b1) r1_cnt++;
      if (MemReq[VALID_BIT] === 1'b1 && !prev_v) mreq_cnt++;
      prev_v = (MemReq[VALID_BIT] === 1'b1);
    end
  end

  function automatic logic [RW-1:0] mk(input logic [BB-1:0] d, input logic t,
                                       input logic [31:0] a);
    return {d, t, 1'b1, a};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_ready(input int port, input int bound, output logic prev_mr);
    int n;
    n = 0;
    prev_mr = 1'b0;
    while ((((port == 0) ? Resp0[0] : Resp1[0]) !== 1'b1) && n < bound) begin
      prev_mr = MemResp[0];
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic wait_memreq(input int bound);
    int n;
    n = 0;
    while (MemReq[VALID_BIT] !== 1'b1 && n < bound) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    logic          pm;
    logic          et_before;
    int            nv, n, r0b, r1b, m0;
    logic [BB-1:0] d1, d2, d3, drd;
    d1  = {4{32'h1111_2222}};
    d2  = {4{32'h3333_4444}};
    d3  = {4{32'h5555_6666}};
    drd = 128'h0fedcba987654321;

    RST  = 1'b0;
    Req0 = '0;
    Req1 = '0;
    tick(2);
    check("rst_memreq", MemReq, '0);
    check("rst_resp0", Resp0, '0);
    check("rst_resp1", Resp1, '0);
    check("rst_err", ErrTimeout, 0);
    RST = 1'b1;
    tick(1);

    // Contention right after reset: port 1 first, then port 0, then port 1 again.
    mem_lat  = 3;
    mem_data = d1;
    Req0 = mk('0, REQUEST_READ, 32'h100);
    Req1 = mk('0, REQUEST_READ, 32'h200);
    tick(1);
    check("cont1_valid", MemReq[VALID_BIT], 1);
    check("cont1_addr", MemReq[31:0], 32'h200);
    wait_ready(1, 20, pm);
    check("cont1_r1_ready", Resp1[0], 1);
    check("cont1_r1_data", Resp1[BB:1], d1);
    check("cont1_r0_quiet", Resp0[0], 0);
    check("cont1_latency", pm, 1);
    Req1 = '0;
    mem_data = d2;
    tick(1);
    check("cont1_r1_pulse", Resp1[0], 0);
    wait_memreq(10);
    check("cont2_addr", MemReq[31:0], 32'h100);
    wait_ready(0, 20, pm);
    check("cont2_r0_ready", Resp0[0], 1);
    check("cont2_r0_data", Resp0[BB:1], d2);
    Req0 = '0;
    tick(3);
    Req0 = mk('0, REQUEST_READ, 32'h110);
    Req1 = mk('0, REQUEST_READ, 32'h210);
    tick(1);
    check("cont3_addr", MemReq[31:0], 32'h210);
    wait_ready(1, 20, pm);
    check("cont3_r1_ready", Resp1[0], 1);
    Req1 = '0;
    tick(1);
    wait_memreq(10);
    check("cont4_addr", MemReq[31:0], 32'h110);
    wait_ready(0, 20, pm);
    check("cont4_r0_ready", Resp0[0], 1);
    Req0 = '0;
    tick(3);
    check("cont_r0_cnt", r0_cnt, 2);
    check("cont_r1_cnt", r1_cnt, 2);

    // Single read, 17-cycle memory; requester drops valid during BUSY.
    mem_lat  = 17;
    mem_data = drd;
    r0b = r0_cnt;
    r1b = r1_cnt;
    check("rd_idle_valid", MemReq[VALID_BIT], 0);
    Req0 = mk('0, REQUEST_READ, 32'h0);
    tick(1);
    check("rd_valid", MemReq[VALID_BIT], 1);
    check("rd_addr", MemReq[31:0], 32'h0);
    check("rd_type", MemReq[TYPE_BIT], REQUEST_READ);
    Req0 = '0;
    wait_ready(0, 40, pm);
    check("rd_ready", Resp0[0], 1);
    check("rd_data", Resp0[BB:1], drd);
    check("rd_latency", pm, 1);
    tick(1);
    check("rd_hold_data", Resp0, {drd, 1'b0});
    tick(3);
    check("rd_r0_pulses", r0_cnt - r0b, 1);
    check("rd_r1_pulses", r1_cnt - r1b, 0);

    // Write on port 1; MemReq must not follow later Req1 changes.
    mem_lat  = 2;
    mem_data = '0;
    r1b = r1_cnt;
    Req1 = mk({BB{1'b1}}, REQUEST_WRITE, 32'h10);
    tick(1);
    check("wr_memreq", MemReq, mk({BB{1'b1}}, REQUEST_WRITE, 32'h10));
    Req1 = mk('0, REQUEST_READ, 32'h20);
    tick(1);
    check("wr_memreq_reg", MemReq, mk({BB{1'b1}}, REQUEST_WRITE, 32'h10));
    wait_ready(1, 20, pm);
    check("wr_ready", Resp1[0], 1);
    Req1 = '0;
    tick(3);
    check("wr_r1_pulses", r1_cnt - r1b, 1);

    // Hold: port 0 keeps valid after ready; port 1 waits, then gets served.
    mem_lat  = 2;
    mem_data = d3;
    m0  = mreq_cnt;
    r1b = r1_cnt;
    Req0 = mk('0, REQUEST_READ, 32'h300);
    tick(1);
    check("hold_addr", MemReq[31:0], 32'h300);
    Req1 = mk('0, REQUEST_READ, 32'h400);
    wait_ready(0, 20, pm);
    check("hold_r0_ready", Resp0[0], 1);
    tick(5);
    check("hold_no_memreq", mreq_cnt - m0, 1);
    check("hold_valid_low", MemReq[VALID_BIT], 0);
    check("hold_r1_off", r1_cnt - r1b, 0);
    Req0 = '0;
    wait_memreq(10);
    check("hold_next_addr", MemReq[31:0], 32'h400);
    wait_ready(1, 20, pm);
    check("hold_r1_data", Resp1[BB:1], d3);
    Req1 = '0;
    tick(3);

    // Timeout: memory never answers.
    mem_lat = 0;
    Req0 = mk('0, REQUEST_READ, 32'h500);
    tick(1);
    n = 0;
    nv = 0;
    et_before = 1'b0;
    while (Resp0[0] !== 1'b1 && n < 100) begin
      if (MemReq[VALID_BIT] === 1'b1) nv++;
      et_before = ErrTimeout;
      @(negedge CLK);
      n++;
    end
    check("to_busy_cycles", nv, 64);
    check("to_err_before", et_before, 0);
    check("to_ready", Resp0[0], 1);
    check("to_data_zero", Resp0[BB:1], '0);
    check("to_err", ErrTimeout, 1);
    check("to_r1_quiet", Resp1[0], 0);
    Req0 = '0;
    tick(3);
    mem_lat = 2;
    Req1 = mk('0, REQUEST_READ, 32'h20);
    wait_ready(1, 20, pm);
    check("to_next_ready", Resp1[0], 1);
    Req1 = '0;
    tick(3);
    check("to_err_sticky", ErrTimeout, 1);

    // Reset during BUSY cycle 3.
    mem_lat = 0;
    r0b = r0_cnt;
    r1b = r1_cnt;
    Req1 = mk('0, REQUEST_READ, 32'h600);
    tick(3);
    check("rb_busy", MemReq[VALID_BIT], 1);
    RST = 1'b0;
    #1;
    check("rb_memreq_zero", MemReq, '0);
    check("rb_resp1_zero", Resp1, '0);
    check("rb_err_clear", ErrTimeout, 0);
    Req1 = '0;
    Req0 = mk('0, REQUEST_READ, 32'h700);
    mem_lat = 2;
    tick(2);
    RST = 1'b1;
    tick(1);
    check("rb_first_grant", MemReq[VALID_BIT], 1);
    check("rb_first_addr", MemReq[31:0], 32'h700);
    check("rb_no_pulse", r1_cnt - r1b, 0);
    wait_ready(0, 20, pm);
    check("rb_after_ready", Resp0[0], 1);
    Req0 = '0;
    tick(3);
    check("rb_r0_pulses", r0_cnt - r0b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_BITS, default 128, gives the cache block width in bits carried on request/response data.
REQ-002 Parameter TIMEOUT, default 64, gives the maximum memory-wait cycles before abort.
REQ-003 CLK  in  1  single clock for all state; rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 Req0  in  34+BLOCK_BITS  request from the instruction cache (port 0): {data, type, valid, addr[31:0]}; type 0 read, 1 write.
REQ-006 Req1  in  34+BLOCK_BITS  request from the data cache (port 1), same format.
REQ-007 Resp0  out  1+BLOCK_BITS  response to port 0: {data, ready}.
REQ-008 Resp1  out  1+BLOCK_BITS  response to port 1, same format.
REQ-009 MemReq  out  34+BLOCK_BITS  request to the memory model, same format as Req0.
REQ-010 MemResp  in  1+BLOCK_BITS  response from memory: {data, ready}.
REQ-011 ErrTimeout  out  1  sticky flag: a memory transaction was aborted by timeout.

Function
REQ-012 States: IDLE, BUSY, RESP, HOLD; reset state IDLE.
REQ-013 IDLE: no valid request -> stay; exactly one valid -> grant it; both valid -> grant the port not granted last (round-robin); first contention after reset grants port 1.
REQ-014 On grant, latch addr, type, data and granted port index in one cycle; next state BUSY; busy counter cleared to 0.
REQ-015 BUSY: MemReq drives the latched request with valid=1; MemReq is fully registered and does not follow later Req changes.
REQ-016 BUSY with MemResp.ready=1: capture MemResp.data, next state RESP, MemReq.valid=0 from the next cycle.
REQ-017 BUSY without ready: counter increments; when counter reaches TIMEOUT-1, set ErrTimeout, capture data as all-zero, next state RESP.
REQ-018 RESP: assert ready on the granted port only, for exactly one cycle, with captured data (also for writes); the other port's ready=0; next state HOLD.
REQ-019 HOLD: MemReq.valid=0; stay until the granted port's valid is 0, then IDLE; guarantees memory sees valid low for at least two cycles between transactions.
REQ-020 A granted requester dropping valid during BUSY does not abort; the transaction completes and the ready pulse is still issued.
REQ-021 A request from the non-granted port is held off (no ready) until a later IDLE grant; no request is lost or duplicated.
REQ-022 Latency: request valid in IDLE cycle n -> MemReq.valid at n+1; MemResp.ready at cycle m -> RespX.ready at m+1.
REQ-023 Last-grant index updates only on grant; ErrTimeout clears only on reset.
REQ-024 Resp data outputs hold the last captured value outside RESP; ready bits are 0 outside RESP.

Reset
REQ-025 RST low immediately forces: state IDLE, MemReq all zero, Resp0/Resp1 all zero, ErrTimeout 0, counter 0, last-grant = port 0 (so first contention grants port 1).
REQ-026 Reset mid-BUSY abandons the transaction without a response; memory observes valid=0 asynchronously.
REQ-027 First grant is possible on the first rising CLK edge after RST returns high.

Structure
REQ-028 Request/response field offsets, widths, and REQUEST_READ/REQUEST_WRITE encodings belong in the shared package mem_pkg, used by caches, memory, and this block.
REQ-029 State encoding is local to mem_arbiter.
REQ-030 The two-way round-robin decision is the sub-module rr_arbiter2 (inputs: two valids, last-grant; outputs: grant valid, grant index).

Verification
REQ-031 Single read: Req0 read addr 0x0 with a 17-cycle memory -> MemReq.valid one cycle later; Resp0.ready pulses once with data 0x0fedcba987654321 one cycle after MemResp.ready; Resp1.ready stays 0.
REQ-032 Contention: Req0 and Req1 valid in the same cycle after reset -> port 1 served first, then port 0; the next simultaneous pair goes to port 1 again.
REQ-033 Write: Req1 write addr 0x10 with data 0xffff...ff -> MemReq carries type 1, addr 0x10, that data; a single Resp1.ready pulse.
REQ-034 Timeout: memory never responds, TIMEOUT=64 -> ErrTimeout=1 after 64 BUSY cycles; Resp0 ready pulse with data 0; ErrTimeout stays 1 until RST.
REQ-035 Hold: the granted port keeps valid high 5 cycles after its ready -> the arbiter stays in HOLD and no second MemReq is issued; the other port is granted after the drop.
REQ-036 Reset mid-BUSY: RST low at BUSY cycle 3 -> MemReq.valid=0 in the same cycle, no ready pulse, IDLE after release.
